// File: rtl/mem_arbiter_if.sv
// Bundle of the core-side and memory-side signals of the memory arbiter.
// The arbiter connects through the slave modport; the environment (core and
// memory models) uses the master modport.
interface mem_arbiter_if;
  logic [31:0] inst_addr_i;
  logic        inst_rd_i;
  logic [31:0] inst_data_o;
  logic        inst_valid_o;
  logic        inst_err_o;

  logic [31:0] data_addr_i;
  logic [31:0] data_data_i;
  logic [1:0]  data_sel_i;
  logic        data_we_i;
  logic        data_rd_i;
  logic [31:0] data_data_o;
  logic        data_valid_o;
  logic        data_err_o;

  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [1:0]  mem_sel_o;
  logic        mem_we_o;
  logic        mem_rd_o;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;

  logic [1:0]  owner_o;

  modport slave (
    input  inst_addr_i, inst_rd_i,
    input  data_addr_i, data_data_i, data_sel_i, data_we_i, data_rd_i,
    input  mem_data_i, mem_valid_i,
    output inst_data_o, inst_valid_o, inst_err_o,
    output data_data_o, data_valid_o, data_err_o,
    output mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_rd_o,
    output owner_o
  );

  modport master (
    output inst_addr_i, inst_rd_i,
    output data_addr_i, data_data_i, data_sel_i, data_we_i, data_rd_i,
    output mem_data_i, mem_valid_i,
    input  inst_data_o, inst_valid_o, inst_err_o,
    input  data_data_o, data_valid_o, data_err_o,
    input  mem_addr_o, mem_data_o, mem_sel_o, mem_we_o, mem_rd_o,
    input  owner_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory bus between instruction fetch
// and data access. Data has priority; a burst counter guarantees fetch gets
// a turn after DATA_BURST_MAX consecutive data grants while fetch waits.
// Each granted request is latched and held on the bus until the memory
// responds or the transaction times out.
module mem_arbiter #(
  parameter int TIMEOUT        = 255,
  parameter int DATA_BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int BW = (DATA_BURST_MAX < 1) ? 1 : $clog2(DATA_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(DATA_BURST_MAX);
  localparam logic [7:0]    TCNT_LIMIT  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic [7:0]    tcnt;
  logic          orphan;

  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    sel_q;
  logic          we_q;
  logic          rd_q;
  logic [1:0]    owner_q;

  logic data_req;
  logic inst_req;
  logic grant_data;
  logic grant_inst;
  logic owner_req;
  logic orphan_now;
  logic at_limit;
  logic done;

  // Request decode and arbitration decision for the current cycle.
  always_comb begin
    data_req   = bus.data_rd_i | bus.data_we_i;
    inst_req   = bus.inst_rd_i;
    grant_data = data_req & ~(inst_req & (burst_cnt == BURST_LIMIT));
    grant_inst = inst_req & ~grant_data;
    owner_req  = (state == INST) ? inst_req : data_req;
    // A request dropped in the very cycle of completion also counts as orphaned.
    orphan_now = orphan | ~owner_req;
    at_limit   = (tcnt == TCNT_LIMIT);
    done       = (state != IDLE) & (bus.mem_valid_i | at_limit);
  end

  // Arbitration FSM: grant in IDLE, hold the latched transaction while owned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      burst_cnt <= '0;
      tcnt      <= '0;
      orphan    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          orphan <= 1'b0;
          if (grant_data) begin
            state   <= DATA;
            owner_q <= 2'b10;
            addr_q  <= bus.data_addr_i;
            wdata_q <= bus.data_data_i;
            sel_q   <= bus.data_sel_i;
            // A simultaneous read and write is treated as a write.
            we_q    <= bus.data_we_i;
            rd_q    <= bus.data_rd_i & ~bus.data_we_i;
            tcnt    <= 8'd1;
            if (inst_req) begin
              if (burst_cnt != BURST_LIMIT) burst_cnt <= burst_cnt + BW'(1);
            end else begin
              burst_cnt <= '0;
            end
          end else if (grant_inst) begin
            state     <= INST;
            owner_q   <= 2'b01;
            addr_q    <= bus.inst_addr_i;
            wdata_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rd_q      <= 1'b1;
            tcnt      <= 8'd1;
            burst_cnt <= '0;
          end
        end
        INST, DATA: begin
          if (done) begin
            state   <= IDLE;
            owner_q <= 2'b00;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            tcnt    <= '0;
            orphan  <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (!owner_req) orphan <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          owner_q <= 2'b00;
          we_q    <= 1'b0;
          rd_q    <= 1'b0;
        end
      endcase
    end
  end

  // Bus side comes straight from the latched registers.
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = wdata_q;
  assign bus.mem_sel_o  = sel_q;
  assign bus.mem_we_o   = we_q;
  assign bus.mem_rd_o   = rd_q;
  assign bus.owner_o    = owner_q;

  // Response routing to the owning port; suppressed for orphaned transactions.
  always_comb begin
    bus.inst_valid_o = (state == INST) & bus.mem_valid_i & ~orphan_now;
    bus.inst_err_o   = (state == INST) & ~bus.mem_valid_i & at_limit & ~orphan_now;
    bus.data_valid_o = (state == DATA) & bus.mem_valid_i & ~orphan_now;
    bus.data_err_o   = (state == DATA) & ~bus.mem_valid_i & at_limit & ~orphan_now;
    bus.inst_data_o  = bus.inst_valid_o ? bus.mem_data_i : 32'h0;
    bus.data_data_o  = bus.data_valid_o ? bus.mem_data_i : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction stream checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TO), .DATA_BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_addr_i = '0;
    bus.inst_rd_i   = 1'b0;
    bus.data_addr_i = '0;
    bus.data_data_i = '0;
    bus.data_sel_i  = '0;
    bus.data_we_i   = 1'b0;
    bus.data_rd_i   = 1'b0;
    bus.mem_data_i  = '0;
    bus.mem_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [176:0] outs;
    bus.data_rd_i = 1'b1;
    bus.inst_rd_i = 1'b1;
    rst = 1'b1;
    step();
    step();
    idle_inputs();
    rst = 1'b0;
    #1;
    outs = {bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o, bus.mem_we_o, bus.mem_rd_o,
            bus.owner_o, bus.inst_data_o, bus.inst_valid_o, bus.inst_err_o,
            bus.data_data_o, bus.data_valid_o, bus.data_err_o, 11'h0};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want all zero", outs);
    end
  endtask

  task automatic test_single_fetch();
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = 32'hDEADBEEF;
    bus.inst_addr_i = 32'h40;
    bus.inst_rd_i   = 1'b1;
    step();
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_rd_o, bus.mem_we_o, bus.mem_addr_o} !== {2'b01, 1'b1, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL fetch_grant: owner=%b rd=%b we=%b addr=%h, want 01 1 0 00000040",
               bus.owner_o, bus.mem_rd_o, bus.mem_we_o, bus.mem_addr_o);
    end
    checks++;
    if ({bus.inst_valid_o, bus.inst_err_o, bus.inst_data_o, bus.data_valid_o} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
      errors++;
      $display("FAIL fetch_response: ivalid=%b ierr=%b idata=%h dvalid=%b, want 1 0 deadbeef 0",
               bus.inst_valid_o, bus.inst_err_o, bus.inst_data_o, bus.data_valid_o);
    end
    step();
    bus.inst_rd_i = 1'b0;
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_rd_o, bus.inst_valid_o, bus.inst_data_o} !== 36'h0) begin
      errors++;
      $display("FAIL fetch_idle_after: owner=%b rd=%b ivalid=%b idata=%h, want all zero",
               bus.owner_o, bus.mem_rd_o, bus.inst_valid_o, bus.inst_data_o);
    end
    bus.mem_valid_i = 1'b0;
  endtask

  task automatic test_priority();
    logic [31:0] md;
    do_reset();
    md = $urandom;
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = md;
    bus.inst_addr_i = 32'h80;
    bus.inst_rd_i   = 1'b1;
    bus.data_addr_i = 32'h100;
    bus.data_rd_i   = 1'b1;
    step();
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_addr_o, bus.data_valid_o, bus.data_data_o, bus.inst_valid_o} !==
        {2'b10, 32'h100, 1'b1, md, 1'b0}) begin
      errors++;
      $display("FAIL priority_data_first: owner=%b addr=%h dvalid=%b ddata=%h ivalid=%b, want 10 00000100 1 %h 0",
               bus.owner_o, bus.mem_addr_o, bus.data_valid_o, bus.data_data_o, bus.inst_valid_o, md);
    end
    step();
    bus.data_rd_i = 1'b0;
    #1;
    checks++;
    if (bus.owner_o !== 2'b00) begin
      errors++;
      $display("FAIL priority_gap: owner=%b, want 00", bus.owner_o);
    end
    step();
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_addr_o, bus.inst_valid_o, bus.inst_data_o} !== {2'b01, 32'h80, 1'b1, md}) begin
      errors++;
      $display("FAIL priority_inst_second: owner=%b addr=%h ivalid=%b idata=%h, want 01 00000080 1 %h",
               bus.owner_o, bus.mem_addr_o, bus.inst_valid_o, bus.inst_data_o, md);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_burst();
    logic [1:0] exp_own [14] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10,
                                 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    do_reset();
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = 32'h5A5A0001;
    bus.inst_addr_i = 32'h44;
    bus.inst_rd_i   = 1'b1;
    bus.data_addr_i = 32'h300;
    bus.data_rd_i   = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      #1;
      checks++;
      if (bus.owner_o !== exp_own[c]) begin
        errors++;
        $display("FAIL burst_owner[%0d]: owner=%b, want %b", c, bus.owner_o, exp_own[c]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_orphan();
    bus.data_addr_i = 32'h200;
    bus.data_data_i = 32'h1234;
    bus.data_sel_i  = 2'b10;
    bus.data_we_i   = 1'b1;
    bus.mem_valid_i = 1'b0;
    step();
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'hFFFF0000;
    bus.data_data_i = 32'h0BADF00D;
    bus.data_sel_i  = 2'b01;
    for (int k = 1; k <= 4; k++) begin
      bus.mem_valid_i = (k == 4);
      bus.mem_data_i  = 32'hCAFE0000;
      #1;
      checks++;
      if ({bus.owner_o, bus.mem_we_o, bus.mem_rd_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o} !==
          {2'b10, 1'b1, 1'b0, 32'h200, 32'h1234, 2'b10}) begin
        errors++;
        $display("FAIL orphan_bus_hold[%0d]: owner=%b we=%b rd=%b addr=%h wdata=%h sel=%b, want 10 1 0 00000200 00001234 10",
                 k, bus.owner_o, bus.mem_we_o, bus.mem_rd_o, bus.mem_addr_o, bus.mem_data_o, bus.mem_sel_o);
      end
      checks++;
      if ({bus.data_valid_o, bus.data_err_o, bus.data_data_o} !== 34'h0) begin
        errors++;
        $display("FAIL orphan_suppress[%0d]: dvalid=%b derr=%b ddata=%h, want 0 0 0",
                 k, bus.data_valid_o, bus.data_err_o, bus.data_data_o);
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL orphan_release: owner=%b we=%b, want 00 0", bus.owner_o, bus.mem_we_o);
    end
  endtask

  task automatic test_timeout();
    bus.inst_addr_i = 32'h50;
    bus.inst_rd_i   = 1'b1;
    bus.mem_valid_i = 1'b0;
    step();
    for (int k = 1; k <= TO; k++) begin
      #1;
      checks++;
      if ({bus.owner_o, bus.mem_rd_o, bus.inst_err_o, bus.inst_valid_o} !== {2'b01, 1'b1, (k == TO), 1'b0}) begin
        errors++;
        $display("FAIL timeout_cycle[%0d]: owner=%b rd=%b ierr=%b ivalid=%b, want 01 1 %b 0",
                 k, bus.owner_o, bus.mem_rd_o, bus.inst_err_o, bus.inst_valid_o, (k == TO));
      end
      step();
    end
    bus.inst_rd_i   = 1'b0;
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = 32'h77777777;
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_rd_o, bus.inst_err_o, bus.inst_valid_o, bus.data_valid_o, bus.inst_data_o} !== 38'h0) begin
      errors++;
      $display("FAIL timeout_late_resp: owner=%b rd=%b ierr=%b ivalid=%b dvalid=%b idata=%h, want all zero",
               bus.owner_o, bus.mem_rd_o, bus.inst_err_o, bus.inst_valid_o, bus.data_valid_o, bus.inst_data_o);
    end
    step();
    bus.mem_valid_i = 1'b0;
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_rd_o} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_stays_idle: owner=%b rd=%b, want 00 0", bus.owner_o, bus.mem_rd_o);
    end
  endtask

  task automatic test_reset_midtxn();
    logic [31:0] md;
    bus.data_addr_i = 32'h600;
    bus.data_rd_i   = 1'b1;
    bus.mem_valid_i = 1'b0;
    step();
    #1;
    checks++;
    if (bus.owner_o !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_grant: owner=%b, want 10", bus.owner_o);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_rd_o, bus.mem_we_o, bus.mem_addr_o, bus.data_valid_o, bus.data_err_o} !== 38'h0) begin
      errors++;
      $display("FAIL rstmid_cleared: owner=%b rd=%b we=%b addr=%h dvalid=%b derr=%b, want all zero",
               bus.owner_o, bus.mem_rd_o, bus.mem_we_o, bus.mem_addr_o, bus.data_valid_o, bus.data_err_o);
    end
    step();
    md = $urandom;
    bus.mem_valid_i = 1'b1;
    bus.mem_data_i  = md;
    #1;
    checks++;
    if ({bus.owner_o, bus.mem_rd_o, bus.mem_addr_o, bus.data_valid_o, bus.data_data_o} !==
        {2'b10, 1'b1, 32'h600, 1'b1, md}) begin
      errors++;
      $display("FAIL rstmid_regrant: owner=%b rd=%b addr=%h dvalid=%b ddata=%h, want 10 1 00000600 1 %h",
               bus.owner_o, bus.mem_rd_o, bus.mem_addr_o, bus.data_valid_o, bus.data_data_o, md);
    end
    step();
    idle_inputs();
  endtask

  // Transaction-level model: each transaction is decided from the arbitration
  // rule and a burst count; latency comes from the chosen wait count.
  task automatic test_random();
    int          mb;
    int          kind;
    int          waits;
    bit          inst_on, data_on, win_d, mv, fin;
    logic [1:0]  op, ds;
    logic [31:0] ia, da, dd, md;
    logic [1:0]  e_own;
    logic [31:0] e_addr;
    logic        e_we, e_rd, e_v, e_e;
    logic [67:0] e_resp, g_resp;
    do_reset();
    mb = 0;
    for (int t = 0; t < 40; t++) begin
      kind    = int'($urandom_range(0, 2));
      inst_on = (kind != 1);
      data_on = (kind != 0);
      ia      = $urandom;
      da      = $urandom;
      dd      = $urandom;
      ds      = 2'($urandom_range(0, 3));
      op      = 2'($urandom_range(1, 3));
      waits   = int'($urandom_range(0, TO + 1));
      win_d   = data_on && !(inst_on && mb == BM);
      if (win_d) mb = inst_on ? ((mb < BM) ? mb + 1 : BM) : 0;
      else       mb = 0;
      e_own  = win_d ? 2'b10 : 2'b01;
      e_addr = win_d ? da : ia;
      e_we   = win_d & op[0];
      e_rd   = win_d ? (op[1] & ~op[0]) : 1'b1;

      bus.inst_rd_i   = inst_on;
      bus.inst_addr_i = ia;
      bus.data_rd_i   = data_on & op[1];
      bus.data_we_i   = data_on & op[0];
      bus.data_addr_i = da;
      bus.data_data_i = dd;
      bus.data_sel_i  = ds;
      bus.mem_valid_i = 1'b0;
      step();
      fin = 1'b0;
      for (int k = 1; k <= TO && !fin; k++) begin
        mv = (k == waits + 1);
        md = $urandom;
        bus.mem_valid_i = mv;
        bus.mem_data_i  = md;
        bus.inst_addr_i = $urandom;
        bus.data_addr_i = $urandom;
        bus.data_data_i = $urandom;
        bus.data_sel_i  = 2'($urandom_range(0, 3));
        e_v = mv;
        e_e = !mv && (k == TO);
        fin = e_v | e_e;
        #1;
        checks++;
        if ({bus.owner_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_rd_o} !== {e_own, e_addr, e_we, e_rd}) begin
          errors++;
          $display("FAIL rand_bus[%0d.%0d]: owner=%b addr=%h we=%b rd=%b, want %b %h %b %b",
                   t, k, bus.owner_o, bus.mem_addr_o, bus.mem_we_o, bus.mem_rd_o, e_own, e_addr, e_we, e_rd);
        end
        if (win_d) begin
          checks++;
          if ({bus.mem_data_o, bus.mem_sel_o} !== {dd, ds}) begin
            errors++;
            $display("FAIL rand_wdata[%0d.%0d]: wdata=%h sel=%b, want %h %b",
                     t, k, bus.mem_data_o, bus.mem_sel_o, dd, ds);
          end
        end
        e_resp = win_d ? {1'b0, 1'b0, 32'h0, e_v, e_e, (e_v ? md : 32'h0)}
                       : {e_v, e_e, (e_v ? md : 32'h0), 1'b0, 1'b0, 32'h0};
        g_resp = {bus.inst_valid_o, bus.inst_err_o, bus.inst_data_o,
                  bus.data_valid_o, bus.data_err_o, bus.data_data_o};
        checks++;
        if (g_resp !== e_resp) begin
          errors++;
          $display("FAIL rand_resp[%0d.%0d]: {iv,ie,idata,dv,de,ddata}=%h, want %h", t, k, g_resp, e_resp);
        end
        step();
      end
      bus.inst_rd_i   = 1'b0;
      bus.data_rd_i   = 1'b0;
      bus.data_we_i   = 1'b0;
      bus.mem_valid_i = 1'b0;
      #1;
      checks++;
      if ({bus.owner_o, bus.mem_we_o, bus.mem_rd_o} !== 4'b0000) begin
        errors++;
        $display("FAIL rand_idle[%0d]: owner=%b we=%b rd=%b, want 00 0 0",
                 t, bus.owner_o, bus.mem_we_o, bus.mem_rd_o);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_priority();
    test_burst();
    test_orphan();
    test_timeout();
    test_reset_midtxn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one memory bus between the core's instruction-fetch port and its data port. Sits between `core` and the memory/cache subsystem. Latches each granted request, holds it on the memory side until `mem_valid_i` arrives or a timeout fires, then routes the response back to the owning port. Data has priority over fetch, with a starvation bound so fetch always makes progress.

Parameters:
- TIMEOUT, 255: max cycles a granted transaction waits for `mem_valid_i` before it is aborted with an error. Range 1..255; the counter is 8 bits.
- DATA_BURST_MAX, 4: max consecutive data grants while a fetch is pending.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- inst_addr_i  in  32  fetch address.
- inst_rd_i  in  1  fetch request; held by the core until it sees valid or err.
- inst_data_o  out  32  fetch data.
- inst_valid_o  out  1  fetch complete.
- inst_err_o  out  1  fetch timed out.
- data_addr_i  in  32  load/store address.
- data_data_i  in  32  store data.
- data_sel_i  in  2  access size code, passed through unchanged.
- data_we_i  in  1  store request.
- data_rd_i  in  1  load request.
- data_data_o  out  32  load data.
- data_valid_o  out  1  data access complete.
- data_err_o  out  1  data access timed out.
- mem_addr_o  out  32  bus address.
- mem_data_o  out  32  bus write data.
- mem_sel_o  out  2  bus size code.
- mem_we_o  out  1  bus write strobe.
- mem_rd_o  out  1  bus read strobe.
- mem_data_i  in  32  bus read data.
- mem_valid_i  in  1  bus transaction complete.
- owner_o  out  2  current owner: 00 none, 01 inst, 10 data.

Behaviour:
- Reset (`rst`=1 at an edge):
  - state goes to IDLE; all outputs 0; burst and timeout counters 0; orphan flag 0.
  - A transaction in flight is abandoned; strobes are low after that edge.
- Request definitions:
  - data_req = `data_rd_i` | `data_we_i`.
  - If `data_rd_i` and `data_we_i` are both 1, the access is a write: `mem_we_o`=1, `mem_rd_o`=0.
  - inst_req = `inst_rd_i`.
- States are IDLE, INST and DATA.
- IDLE:
  - `owner_o`=00; all mem strobes 0; `mem_valid_i` is ignored, so late responses are discarded.
  - On an edge with a request present, the arbiter grants and latches addr/data/sel/we/rd of the winner into the mem_* registers.
  - If both requests are present, data wins unless burst_cnt == DATA_BURST_MAX; then inst wins.
- Burst counter (burst_cnt):
  - On a data grant: increments, saturating, if inst_req was pending at the grant; otherwise cleared.
  - On an inst grant: cleared.
- INST/DATA (owner state):
  - mem_* outputs are driven from the latched registers only, so they are stable for the whole transaction even if the core's inputs change.
  - `owner_o` is 01 in INST and 10 in DATA.
  - tcnt is 1 in the first owner cycle and increments each cycle.
- Completion: the first owner cycle with `mem_valid_i`=1.
  - In that same cycle, combinationally: owner's `*_valid_o`=1 and `*_data_o`=`mem_data_i`, unless orphaned.
  - Next state is IDLE.
  - Minimum latency: request in IDLE at cycle N; strobes high at N+1; valid at N+1 with a zero-wait memory.
  - There is one IDLE cycle between transactions, so the repeated request from the completing port is not regranted.
- Orphan:
  - If the owner's request drops before completion, the orphan flag is set.
  - The transaction still runs to completion or timeout on the bus, since the bus has no abort.
  - `valid_o` and `err_o` are suppressed for it.
  - The flag clears on return to IDLE.
- Timeout: if tcnt == TIMEOUT and `mem_valid_i`=0:
  - the owner's `err_o`=1 for that cycle, unless orphaned;
  - `valid_o` stays 0;
  - next state is IDLE, so strobes drop at the next edge.
- `valid_o` and `err_o` are never both 1. The non-owner port's `valid_o`/`err_o` are always 0.
- `*_data_o` is 0 whenever the corresponding `valid_o` is 0.

Test Plan:
1. `mem_valid_i` tied 1, `mem_data_i`=0xDEADBEEF, `inst_rd_i`=1 with `inst_addr_i`=0x40 → next cycle:
   - `owner_o`=01, `mem_rd_o`=1, `mem_addr_o`=0x40;
   - `inst_valid_o`=1 and `inst_data_o`=0xDEADBEEF in the same cycle;
   - IDLE the following cycle.
2. `inst_rd_i` and `data_rd_i` (0x100) rise together → DATA granted first, `mem_addr_o`=0x100; IDLE; then INST granted with `mem_addr_o`=`inst_addr_i`.
3. `data_rd_i` and `inst_rd_i` held continuously, DATA_BURST_MAX=4, zero-wait memory → 4 data grants, then an inst grant, then data grants resume.
4. Data write to 0x200 with `data_data_i`=0x1234 and `mem_valid_i` low for 3 cycles; `data_we_i` drops after 1 cycle →
   - `mem_we_o`=1, `mem_addr_o`=0x200, `mem_data_o`=0x1234 held for all 4 cycles;
   - `data_valid_o` stays 0 when `mem_valid_i` arrives.
5. TIMEOUT=8, `mem_valid_i`=0, `inst_rd_i`=1 →
   - `inst_err_o`=1 in the 8th owner cycle only; strobes 0 next cycle;
   - a `mem_valid_i` pulse in IDLE produces no valid.
6. `rst` asserted in the 2nd cycle of a pending DATA read → next cycle all outputs are 0 and `owner_o`=00; after release, a new request is granted normally.
